// File: rtl/t1_t2_pkg.sv
// Shared Tier-1/Tier-2 types: arbiter FSM encoding, pass_plane codes, FIFO entry tag width.
package t1_t2_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    PASS_SP = 2'd0,
    PASS_MP = 2'd1,
    PASS_CP = 2'd2
  } pass_plane_t;

  // FIFO entry = {cb_last, pass[1:0], data}
  localparam int unsigned TAG_W = 3;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/t1_cb_arbiter_if.sv
// Channel-side and Tier-2-side handshake bundle for the codeblock arbiter.
interface t1_cb_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH*2-1:0]      ch_pass;
  logic [NUM_CH-1:0]        ch_cb_last;

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               out_pass;
  logic                     out_cb_last;
  logic [CH_W-1:0]          out_ch_id;

  modport master (
    output ch_valid, ch_data, ch_pass, ch_cb_last, out_ready,
    input  ch_ready, out_valid, out_data, out_pass, out_cb_last, out_ch_id
  );

  modport slave (
    input  ch_valid, ch_data, ch_pass, ch_cb_last, out_ready,
    output ch_ready, out_valid, out_data, out_pass, out_cb_last, out_ch_id
  );
endinterface

// File: rtl/t1_cb_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head whenever not empty.
module t1_cb_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/t1_cb_arbiter.sv
// Round-robin codeblock arbiter: per-channel FWFT FIFOs drained one whole codeblock at a time.
// Optional per-channel codeblock counters are enabled by defining T1_CB_ARB_STATS_EN.
module t1_cb_arbiter
  import t1_t2_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_dwt,
  input  logic                 rst,
  t1_cb_arbiter_if.slave       bus,
  output logic                 all_idle
`ifdef T1_CB_ARB_STATS_EN
  ,
  output logic [NUM_CH*16-1:0] cb_count
`endif
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ENT_W = DATA_W + TAG_W;

  arb_state_t        state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_ptr;
  logic              port_en;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;
  logic [ENT_W-1:0]  head [NUM_CH];
  logic [ENT_W-1:0]  head_sel;
  logic              any_pend;
  logic [CH_W-1:0]   pick;
  logic              xfer;
  logic              xfer_last;

  // ch_ready stays low until the first clock after reset release.
  assign bus.ch_ready = port_en ? ~fifo_full : '0;
  assign wr_en        = bus.ch_valid & bus.ch_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    t1_cb_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk_dwt),
      .rst_n   (rst),
      .wr_en   (wr_en[k]),
      .wr_data ({bus.ch_cb_last[k], bus.ch_pass[k*2 +: 2], bus.ch_data[k*DATA_W +: DATA_W]}),
      .rd_en   (rd_en[k]),
      .rd_data (head[k]),
      .empty   (fifo_empty[k]),
      .full    (fifo_full[k])
    );
    assign rd_en[k] = xfer && (grant == CH_W'(k));
  end

  assign head_sel        = head[grant];
  assign bus.out_valid   = (state == ST_BURST) && !fifo_empty[grant];
  assign xfer            = bus.out_valid && bus.out_ready;
  assign xfer_last       = xfer && head_sel[ENT_W-1];
  assign bus.out_data    = (state == ST_BURST) ? head_sel[DATA_W-1:0] : '0;
  assign bus.out_pass    = (state == ST_BURST) ? head_sel[DATA_W +: 2] : '0;
  assign bus.out_cb_last = (state == ST_BURST) ? head_sel[ENT_W-1] : 1'b0;
  assign bus.out_ch_id   = (state == ST_BURST) ? grant : '0;
  assign all_idle        = port_en && (state == ST_IDLE) && (&fifo_empty);

  // Scan from highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int j;
    logic [CH_W-1:0] idx;
    any_pend = 1'b0;
    pick     = rr_ptr;
    j        = 0;
    idx      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      idx = CH_W'(j);
      if (!fifo_empty[idx]) begin
        any_pend = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      port_en <= 1'b0;
    end else begin
      port_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (any_pend) begin
            state <= ST_BURST;
            grant <= pick;
          end
        end
        ST_BURST: begin
          if (xfer_last) begin
            state  <= ST_IDLE;
            rr_ptr <= CH_W'(wrap_inc(int'(grant), NUM_CH));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef T1_CB_ARB_STATS_EN
  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      cb_count <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (xfer_last && (grant == CH_W'(k)))
          cb_count[k*16 +: 16] <= cb_count[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_t1_cb_arbiter.sv
// Directed bench for t1_cb_arbiter: scoreboard of expected output words, bubble and reset checks.
module tb_t1_cb_arbiter;
  import t1_t2_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 16;

  logic clk_dwt = 1'b0;
  logic rst     = 1'b0;
  logic all_idle;
`ifdef T1_CB_ARB_STATS_EN
  logic [NUM_CH*16-1:0] cb_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic bubble_pending = 1'b0;

  t1_cb_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  t1_cb_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_dwt  (clk_dwt),
    .rst      (rst),
    .bus      (bus),
    .all_idle (all_idle)
`ifdef T1_CB_ARB_STATS_EN
    ,
    .cb_count (cb_count)
`endif
  );

  always #5 clk_dwt = ~clk_dwt;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_word(input int ch, input logic [15:0] d,
                                            input logic [1:0] p, input logic last);
    return {11'd0, 2'(ch), last, p, d};
  endfunction

  // Scoreboard: every accepted output word must match the queue head in order.
  always @(negedge clk_dwt) begin
    if (rst) begin
      if (bubble_pending) begin
        chk("bubble_after_last", bus.out_valid, 1'b0);
        bubble_pending = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0)
          chk("unexpected_word_q_size", exp_q.size(), 1);
        else
          chk("out_word", {11'd0, bus.out_ch_id, bus.out_cb_last, bus.out_pass, bus.out_data},
              exp_q.pop_front());
        if (bus.out_cb_last) bubble_pending = 1'b1;
      end
    end else begin
      bubble_pending = 1'b0;
    end
  end

  task automatic drive(input int ch, input logic [15:0] d, input logic [1:0] p, input logic last);
    bus.ch_valid[ch]                 = 1'b1;
    bus.ch_data[ch*DATA_W +: DATA_W] = d;
    bus.ch_pass[ch*2 +: 2]           = p;
    bus.ch_cb_last[ch]               = last;
  endtask

  task automatic push(input int ch, input logic [15:0] d, input logic [1:0] p, input logic last);
    exp_q.push_back(pack_word(ch, d, p, last));
  endtask

  task automatic step();
    @(posedge clk_dwt);
    #1;
    bus.ch_valid   = '0;
    bus.ch_cb_last = '0;
  endtask

  task automatic send(input int ch, input logic [15:0] d, input logic [1:0] p, input logic last);
    drive(ch, d, p, last);
    push(ch, d, p, last);
    step();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk_dwt);
    repeat (2) @(posedge clk_dwt);
    #1;
    chk("drain_words_left", exp_q.size(), 0);
  endtask

  initial begin
    bus.ch_valid   = '0;
    bus.ch_data    = '0;
    bus.ch_pass    = '0;
    bus.ch_cb_last = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_dwt);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_ch_ready", bus.ch_ready, 4'b0000);
    chk("rst_all_idle", all_idle, 1'b0);
    chk("rst_out_data", bus.out_data, 16'h0);
    chk("rst_out_ch_id", bus.out_ch_id, 2'd0);
    #1 rst = 1'b1;
    @(posedge clk_dwt);
    #1;
    chk("rel_ch_ready", bus.ch_ready, 4'b1111);
    chk("rel_all_idle", all_idle, 1'b1);
    chk("rel_out_valid", bus.out_valid, 1'b0);

    // ch0 five-word codeblock streaming straight through
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(0, 16'h0100 + 16'(i), 2'(i % 3), (i == 4));
    drain(50);
    chk("cb0_all_idle", all_idle, 1'b1);

    // One-word ch1 codeblock moves the pointer to 2
    send(1, 16'h0200, PASS_CP, 1'b1);
    drain(20);

    // ch1 and ch3 both hold full codeblocks with pointer 2: ch3 first
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h1100 + 16'(i), 2'(i), (i == 2));
      drive(3, 16'h3300 + 16'(i), 2'(2 - i), (i == 2));
      step();
    end
    for (int i = 0; i < 3; i++) push(3, 16'h3300 + 16'(i), 2'(2 - i), (i == 2));
    for (int i = 0; i < 3; i++) push(1, 16'h1100 + 16'(i), 2'(i), (i == 2));
    bus.out_ready = 1'b1;
    drain(60);

    // Pointer now 2 again (ch3 -> 0, ch1 -> 2): ch2 beats ch1
    bus.out_ready = 1'b0;
    drive(1, 16'h1500, PASS_SP, 1'b1);
    drive(2, 16'h2500, PASS_MP, 1'b1);
    step();
    push(2, 16'h2500, PASS_MP, 1'b1);
    push(1, 16'h1500, PASS_SP, 1'b1);
    bus.out_ready = 1'b1;
    drain(30);

    // Fill ch2 to capacity with the output stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      send(2, 16'h2000 + 16'(i), 2'(i % 3), (i == FIFO_DEPTH - 1));
      if (i == FIFO_DEPTH - 2) chk("fill_ready_before_full", bus.ch_ready[2], 1'b1);
    end
    chk("full_ready", bus.ch_ready[2], 1'b0);
    chk("full_other_ready", bus.ch_ready, 4'b1011);
    chk("full_out_valid_stalled", bus.out_valid, 1'b1);
    chk("full_stable_data", bus.out_data, 16'h2000);
    drive(2, 16'h2FFF, PASS_SP, 1'b1);
    step();
    chk("overflow_ready", bus.ch_ready[2], 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk_dwt);
    #1;
    bus.out_ready = 1'b0;
    chk("ready_restored", bus.ch_ready[2], 1'b1);
    bus.out_ready = 1'b1;
    drain(80);
    chk("fill_all_idle", all_idle, 1'b1);

    // Reset in the middle of a ch0 codeblock
    bus.out_ready = 1'b1;
    send(0, 16'h0A00, PASS_SP, 1'b0);
    send(0, 16'h0A01, PASS_MP, 1'b0);
    send(0, 16'h0A02, PASS_CP, 1'b0);
    chk("midcb_out_valid", bus.out_valid, 1'b1);
    @(posedge clk_dwt);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_ch_ready", bus.ch_ready, 4'b0000);
    chk("midrst_all_idle", all_idle, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk_dwt);
    #1 rst = 1'b1;
    @(posedge clk_dwt);
    #1;
    chk("postrst_ch_ready", bus.ch_ready, 4'b1111);
    chk("postrst_all_idle", all_idle, 1'b1);
    send(0, 16'h0B00, PASS_MP, 1'b0);
    send(0, 16'h0B01, PASS_CP, 1'b1);
    drain(30);
    chk("postrst_end_idle", all_idle, 1'b1);

`ifdef T1_CB_ARB_STATS_EN
    @(posedge clk_dwt);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk_dwt);
    #1 rst = 1'b1;
    @(posedge clk_dwt);
    #1;
    chk("stats_reset", cb_count, 64'h0);
    for (int c = 0; c < 3; c++) begin
      send(1, 16'h5000 + 16'(c), PASS_SP, 1'b0);
      send(1, 16'h5100 + 16'(c), PASS_CP, 1'b1);
    end
    drain(60);
    chk("stats_count", cb_count, 64'h0000_0000_0003_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/t1_cb_arbiter.md
T1_CB_ARBITER -- requirements
Module: t1_cb_arbiter

Interface
- REQ-001 SHALL have parameter NUM_CH, default 4: number of Tier-1 coder channels (2..8).
- REQ-002 SHALL have parameter DATA_W, default 16: MQ output word width.
- REQ-003 SHALL have parameter FIFO_DEPTH, default 16: words per channel FIFO (power of 2, >=4).
- REQ-004 SHALL have port clk_dwt, input, 1: the single clock; all logic on its rising edge.
- REQ-005 SHALL have port rst, input, 1: reset, asynchronous assertion, active-low.
- REQ-006 SHALL have port ch_valid, input, NUM_CH: channel word valid.
- REQ-007 SHALL have port ch_data, input, NUM_CH*DATA_W: channel k data in slice [k*DATA_W +: DATA_W].
- REQ-008 SHALL have port ch_pass, input, NUM_CH*2: pass_plane tag per word (0 SP, 1 MP, 2 CP).
- REQ-009 SHALL have port ch_cb_last, input, NUM_CH: word is the final word of its codeblock.
- REQ-010 SHALL have port ch_ready, output, NUM_CH: channel FIFO can accept a word.
- REQ-011 SHALL have port out_valid / out_ready, output / input, 1 each: Tier-2 side handshake.
- REQ-012 SHALL have ports out_data (DATA_W), out_pass (2), out_cb_last (1), out_ch_id ($clog2(NUM_CH)), all outputs.
- REQ-013 SHALL have port all_idle, output, 1: all FIFOs empty and FSM in IDLE.

Function
- REQ-014 SHALL write a word to FIFO k when ch_valid[k] && ch_ready[k]; ch_ready[k] = (count_k < FIFO_DEPTH), independent of same-cycle reads.
- REQ-015 SHALL transfer an output word when out_valid && out_ready; out_* SHALL be stable while out_valid && !out_ready.
- REQ-016 SHALL present FIFO head first-word-fall-through; a word written in cycle n is visible on out_* no earlier than cycle n+1.
- REQ-017 SHALL implement FSM IDLE/BURST: IDLE -> BURST when any FIFO non-empty, granting the lowest-index non-empty channel at or after the round-robin pointer.
- REQ-018 SHALL keep the grant in BURST until the word with cb_last=1 is transferred; codeblocks from different channels never interleave.
- REQ-019 SHALL on that transfer advance the pointer to grant+1 (mod NUM_CH, wrapping NUM_CH-1 -> 0) and return to IDLE; out_valid is 0 in IDLE (one bubble cycle per codeblock).
- REQ-020 SHALL drive out_valid=0 in BURST while the granted FIFO is empty (underrun stall), without changing grant.
- REQ-021 SHALL handle simultaneous write and read on one FIFO with count unchanged; pointers wrap modulo FIFO_DEPTH.
- REQ-022 SHALL drive out_ch_id = granted channel index, constant across a codeblock.

Reset
- REQ-023 SHALL on rst low asynchronously clear FIFOs, counts, pointer (0), FSM (IDLE); outputs: out_valid=0, out_data/out_pass/out_cb_last/out_ch_id=0, ch_ready=0, all_idle=0.
- REQ-024 SHALL deassert reset synchronously to clk_dwt; first cycle after release ch_ready=all 1, all_idle=1.
- REQ-025 SHALL discard any partial codeblock on reset mid-BURST; no recovery state retained.

Configuration
- REQ-026 SHALL with T1_CB_ARB_STATS_EN defined add output cb_count (NUM_CH*16), per-channel 16-bit wrapping count of transferred cb_last words, reset to 0.
- REQ-027 SHALL without T1_CB_ARB_STATS_EN omit cb_count port and its logic entirely.

Structure
- REQ-028 SHALL place FSM state encoding (IDLE=0, BURST=1) and pass_plane codes in shared package t1_t2_pkg.
- REQ-029 SHALL instantiate one sub-module t1_cb_fifo (sync FWFT FIFO, DATA_W+3 bits wide) per channel via generate.

Verification
- REQ-030 SHALL cover: reset release -> ch_ready=4'b1111, all_idle=1, out_valid=0.
- REQ-031 SHALL cover: ch0 sends 5-word codeblock, out_ready=1 -> 5 words on out with out_ch_id=0, cb_last only on 5th, then one out_valid=0 cycle.
- REQ-032 SHALL cover: ch1 and ch3 both hold complete 3-word codeblocks, pointer=2 -> ch3 drained fully before ch1; pointer then 0 then 2.
- REQ-033 SHALL cover: ch2 writes 16 words with out_ready=0 -> ch_ready[2]=0 after 16th write, 17th word not accepted; one read restores ch_ready[2] next cycle.
- REQ-034 SHALL cover: rst pulsed low mid-codeblock on ch0 -> out_valid=0 immediately, next codeblock starts from ch0 with no stale words.
- REQ-035 SHALL cover with T1_CB_ARB_STATS_EN: 3 codeblocks from ch1 -> cb_count slice 1 = 3, others 0.
